yurut_birim_zamanlayici: RTL and testbench

//   Issue scheduler for the execute stage's multi-cycle units: AMB, yapay zeka hizlandirici, kriptografi birimi.

---
 rtl/yurut_birim_zamanlayici_if.sv | 38 +++
 rtl/yurut_birim_zamanlayici.sv | 150 +++++++++++++++
 tb/tb_yurut_birim_zamanlayici.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/yurut_birim_zamanlayici_if.sv
// Bundle between decode / multi-cycle units and the execute-stage issue scheduler.
// slave: the scheduler side; master: the decode and unit side that drives requests and done pulses.
interface yurut_birim_zamanlayici_if #(
    parameter int VERI_W   = 32,
    parameter int YAZMAC_W = 5
);
    logic                durdur_i;
    logic                istek_gecerli_i;
    logic [1:0]          birim_sec_i;
    logic [YAZMAC_W-1:0] hedef_yazmaci_i;
    logic                yazmaca_yaz_i;
    logic [2:0]          birim_hazir_i;
    logic [VERI_W-1:0]   amb_sonuc_i;
    logic [VERI_W-1:0]   yz_sonuc_i;
    logic [VERI_W-1:0]   kripto_sonuc_i;

    logic [2:0]          baslat_o;
    logic                yurut_stall_o;
    logic                sonuc_gecerli_o;
    logic [VERI_W-1:0]   sonuc_o;
    logic [YAZMAC_W-1:0] hedef_yazmaci_o;
    logic                yazmaca_yaz_o;
    logic                hata_o;

    modport master (
        output durdur_i, istek_gecerli_i, birim_sec_i, hedef_yazmaci_i, yazmaca_yaz_i,
        output birim_hazir_i, amb_sonuc_i, yz_sonuc_i, kripto_sonuc_i,
        input  baslat_o, yurut_stall_o, sonuc_gecerli_o, sonuc_o, hedef_yazmaci_o,
        input  yazmaca_yaz_o, hata_o
    );

    modport slave (
        input  durdur_i, istek_gecerli_i, birim_sec_i, hedef_yazmaci_i, yazmaca_yaz_i,
        input  birim_hazir_i, amb_sonuc_i, yz_sonuc_i, kripto_sonuc_i,
        output baslat_o, yurut_stall_o, sonuc_gecerli_o, sonuc_o, hedef_yazmaci_o,
        output yazmaca_yaz_o, hata_o
    );
endinterface

// File: rtl/yurut_birim_zamanlayici.sv
// Issue scheduler for the execute stage's multi-cycle units (AMB, YZ, KRIPTO): start, stall, write back.
// Optional watchdog: define YURUT_ZAMAN_ASIMI_EN to abort a unit that never reports done.
module yurut_birim_zamanlayici #(
    parameter int VERI_W      = 32,
    parameter int YAZMAC_W    = 5,
    parameter int ZAMAN_ASIMI = 64
) (
    input logic                      clk_i,
    input logic                      rst_i,
    yurut_birim_zamanlayici_if.slave bus
);
    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        MESGUL = 2'd1,
        YAZ    = 2'd2
    } durum_t;

    durum_t              durum;
    durum_t              durum_sonraki;

    logic [1:0]          sec_q;
    logic [YAZMAC_W-1:0] hedef_q;
    logic                yaz_q;
    logic [2:0]          baslat_q;
    logic [VERI_W-1:0]   sonuc_q;
    logic                bekleyen_q;
    logic                hata_q;

    logic                kabul;
    logic                ayrilmis;
    logic                secili_hazir;
    logic                tamam;
    logic                zaman_asimi;
    logic [VERI_W-1:0]   secili_sonuc;
    logic [2:0]          baslat_d;

    assign kabul    = (durum == BOSTA) && bus.istek_gecerli_i && !bus.durdur_i
                      && (bus.birim_sec_i != 2'b11);
    assign ayrilmis = (durum == BOSTA) && bus.istek_gecerli_i && !bus.durdur_i
                      && (bus.birim_sec_i == 2'b11);
    assign tamam    = secili_hazir || bekleyen_q;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        secili_hazir = 1'b0;
        secili_sonuc = '0;
        baslat_d     = 3'b000;
        case (sec_q)
            2'b00:   begin secili_hazir = bus.birim_hazir_i[0]; secili_sonuc = bus.amb_sonuc_i;    end
            2'b01:   begin secili_hazir = bus.birim_hazir_i[1]; secili_sonuc = bus.yz_sonuc_i;     end
            2'b10:   begin secili_hazir = bus.birim_hazir_i[2]; secili_sonuc = bus.kripto_sonuc_i; end
            default: ;
        endcase
        case (bus.birim_sec_i)
            2'b00:   baslat_d = 3'b001;
            2'b01:   baslat_d = 3'b010;
            2'b10:   baslat_d = 3'b100;
            default: ;
        endcase
    end

`ifdef YURUT_ZAMAN_ASIMI_EN
    localparam int SAYAC_W = $clog2(ZAMAN_ASIMI + 1);
    logic [SAYAC_W-1:0] sayac_q;

    // The abort fires on the non-frozen MESGUL cycle that would bring the count to ZAMAN_ASIMI.
    assign zaman_asimi = (durum == MESGUL) && !bus.durdur_i && !tamam
                         && (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sayac_q <= '0;
        end else if (kabul) begin
            sayac_q <= '0;
        end else if ((durum == MESGUL) && !bus.durdur_i) begin
            sayac_q <= sayac_q + SAYAC_W'(1);
        end
    end
`else
    assign zaman_asimi = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki = durum;
        unique case (durum)
            BOSTA: begin
                if (kabul) durum_sonraki = MESGUL;
            end
            MESGUL: begin
                if (!bus.durdur_i && (tamam || zaman_asimi)) durum_sonraki = YAZ;
            end
            YAZ: begin
                if (!bus.durdur_i) durum_sonraki = BOSTA;
            end
            default: durum_sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sec_q      <= 2'b00;
            hedef_q    <= '0;
            yaz_q      <= 1'b0;
            baslat_q   <= 3'b000;
            sonuc_q    <= '0;
            bekleyen_q <= 1'b0;
            hata_q     <= 1'b0;
        end else begin
            baslat_q <= kabul ? baslat_d : 3'b000;
            hata_q   <= ayrilmis || zaman_asimi;

            if (kabul) begin
                sec_q      <= bus.birim_sec_i;
                hedef_q    <= bus.hedef_yazmaci_i;
                yaz_q      <= bus.yazmaca_yaz_i;
                bekleyen_q <= 1'b0;
            end

            if (durum == MESGUL) begin
                if (zaman_asimi) begin
                    sonuc_q <= '0;
                    yaz_q   <= 1'b0;
                end else if (secili_hazir && !bekleyen_q) begin
                    // A done seen under freeze is remembered until the pipeline moves again.
                    sonuc_q    <= secili_sonuc;
                    bekleyen_q <= bus.durdur_i;
                end else if (!bus.durdur_i) begin
                    bekleyen_q <= 1'b0;
                end
            end
        end
    end

    assign bus.baslat_o        = baslat_q;
    assign bus.yurut_stall_o   = (durum != BOSTA);
    assign bus.sonuc_gecerli_o = (durum == YAZ);
    assign bus.yazmaca_yaz_o   = (durum == YAZ) && yaz_q;
    assign bus.sonuc_o         = sonuc_q;
    assign bus.hedef_yazmaci_o = hedef_q;
    assign bus.hata_o          = hata_q;
endmodule

// File: tb/tb_yurut_birim_zamanlayici.sv
// Self-checking bench for yurut_birim_zamanlayici: table vectors, directed corner sequences, random ops.
// The watchdog sequence runs only when YURUT_ZAMAN_ASIMI_EN is defined.
module tb_yurut_birim_zamanlayici;
    localparam int VERI_W      = 32;
    localparam int YAZMAC_W    = 5;
    localparam int ZAMAN_ASIMI = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    yurut_birim_zamanlayici_if #(.VERI_W(VERI_W), .YAZMAC_W(YAZMAC_W)) bus ();

    yurut_birim_zamanlayici #(
        .VERI_W(VERI_W), .YAZMAC_W(YAZMAC_W), .ZAMAN_ASIMI(ZAMAN_ASIMI)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        int          lat;
        logic [31:0] data;
        int          frz_pct;
        int          stray_pct;
        logic [2:0]  exp_start;
        logic        exp_hata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.durdur_i        = 1'b0;
        bus.istek_gecerli_i = 1'b0;
        bus.birim_sec_i     = 2'b00;
        bus.hedef_yazmaci_i = '0;
        bus.yazmaca_yaz_i   = 1'b0;
        bus.birim_hazir_i   = 3'b000;
        bus.amb_sonuc_i     = '0;
        bus.yz_sonuc_i      = '0;
        bus.kripto_sonuc_i  = '0;
    endtask

    // Reference: the unit answers lat cycles after its start pulse (lat=1 means same cycle as the
    // pulse); write-back follows the first unfrozen cycle once the answer exists and lasts one
    // unfrozen cycle; the scheduler is busy from acceptance until that beat has been consumed.
    task automatic run_op(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                          input int lat, input logic [31:0] data, input int frz_pct,
                          input int stray_pct, input logic [2:0] exp_start, input logic exp_hata);
        bit   busy, in_wb, got, done_sent;
        int   since, dut_beats;
        logic [2:0] h;
        idle_inputs();
        bus.istek_gecerli_i = 1'b1;
        bus.birim_sec_i     = sel;
        bus.hedef_yazmaci_i = rd;
        bus.yazmaca_yaz_i   = we;
        busy = (sel != 2'b11);
        in_wb = 0; got = 0; done_sent = 0; since = 0; dut_beats = 0;
        tick();
        bus.istek_gecerli_i = 1'b0;
        bus.hedef_yazmaci_i = ~rd;
        bus.yazmaca_yaz_i   = ~we;
        bus.birim_sec_i     = 2'($urandom_range(3));
        for (int cyc = 0; cyc < 300; cyc++) begin
            check("baslat", bus.baslat_o, (cyc == 0) ? exp_start : 3'b000);
            check("hata", bus.hata_o, (cyc == 0) ? exp_hata : 1'b0);
            check("stall", bus.yurut_stall_o, busy);
            check("gecerli", bus.sonuc_gecerli_o, in_wb);
            check("yaz_en", bus.yazmaca_yaz_o, in_wb && we);
            if (in_wb) begin
                check("sonuc", bus.sonuc_o, data);
                check("hedef", bus.hedef_yazmaci_o, rd);
            end
            if (!busy) break;
            bus.durdur_i       = ($urandom_range(99) < frz_pct);
            bus.amb_sonuc_i    = $urandom;
            bus.yz_sonuc_i     = $urandom;
            bus.kripto_sonuc_i = $urandom;
            h = 3'b000;
            for (int b = 0; b < 3; b++)
                if (b != int'(sel) && $urandom_range(99) < stray_pct) h[b] = 1'b1;
            if (!done_sent && since == lat - 1) begin
                h[sel] = 1'b1;
                done_sent = 1;
                case (sel)
                    2'b00:   bus.amb_sonuc_i    = data;
                    2'b01:   bus.yz_sonuc_i     = data;
                    default: bus.kripto_sonuc_i = data;
                endcase
            end
            bus.birim_hazir_i = h;
            since++;
            if (bus.sonuc_gecerli_o && !bus.durdur_i) dut_beats++;
            if (in_wb) begin
                if (!bus.durdur_i) begin in_wb = 0; busy = 0; end
            end else if (busy) begin
                if (h[sel]) got = 1;
                if (got && !bus.durdur_i) in_wb = 1;
            end
            tick();
        end
        check("op_bitti", bus.yurut_stall_o, 1'b0);
        check("beat_sayisi", dut_beats, (sel != 2'b11) ? 1 : 0);
        idle_inputs();
        tick();
        check("sonra_hata", bus.hata_o, 1'b0);
        check("sonra_baslat", bus.baslat_o, 3'b000);
        check("sonra_gecerli", bus.sonuc_gecerli_o, 1'b0);
    endtask

    initial begin
        vecs[0] = '{2'b00, 5'd5,  1'b1, 3, 32'h0000_00AA, 0,  0,   3'b001, 1'b0};
        vecs[1] = '{2'b10, 5'd12, 1'b1, 4, 32'hDEAD_BEEF, 0,  100, 3'b100, 1'b0};
        vecs[2] = '{2'b01, 5'd31, 1'b0, 1, 32'h1234_5678, 0,  50,  3'b010, 1'b0};
        vecs[3] = '{2'b11, 5'd7,  1'b1, 1, 32'h0,         0,  0,   3'b000, 1'b1};
        vecs[4] = '{2'b00, 5'd0,  1'b1, 1, 32'hFFFF_FFFF, 40, 0,   3'b001, 1'b0};
        vecs[5] = '{2'b01, 5'd17, 1'b1, 6, 32'h0BAD_F00D, 60, 30,  3'b010, 1'b0};

        // Reset state with a request present
        idle_inputs();
        bus.istek_gecerli_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_baslat", bus.baslat_o, 3'b000);
        check("rst_stall", bus.yurut_stall_o, 1'b0);
        check("rst_gecerli", bus.sonuc_gecerli_o, 1'b0);
        check("rst_yaz", bus.yazmaca_yaz_o, 1'b0);
        check("rst_hata", bus.hata_o, 1'b0);
        check("rst_sonuc", bus.sonuc_o, 32'h0);
        check("rst_hedef", bus.hedef_yazmaci_o, 5'h0);
        idle_inputs();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].sel, vecs[i].rd, vecs[i].we, vecs[i].lat, vecs[i].data,
                   vecs[i].frz_pct, vecs[i].stray_pct, vecs[i].exp_start, vecs[i].exp_hata);

        // YZ done arrives in the first of four frozen cycles
        idle_inputs();
        bus.istek_gecerli_i = 1'b1; bus.birim_sec_i = 2'b01;
        bus.hedef_yazmaci_i = 5'd9; bus.yazmaca_yaz_i = 1'b1;
        tick();
        bus.istek_gecerli_i = 1'b0;
        check("frz_baslat", bus.baslat_o, 3'b010);
        bus.durdur_i = 1'b1; bus.birim_hazir_i = 3'b010; bus.yz_sonuc_i = 32'hCAFE_0001;
        tick();
        bus.birim_hazir_i = 3'b000; bus.yz_sonuc_i = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            check("frz_bekle_gecerli", bus.sonuc_gecerli_o, 1'b0);
            check("frz_bekle_stall", bus.yurut_stall_o, 1'b1);
            tick();
        end
        check("frz_son_gecerli", bus.sonuc_gecerli_o, 1'b0);
        bus.durdur_i = 1'b0;
        tick();
        check("frz_yaz_gecerli", bus.sonuc_gecerli_o, 1'b1);
        check("frz_yaz_sonuc", bus.sonuc_o, 32'hCAFE_0001);
        check("frz_yaz_hedef", bus.hedef_yazmaci_o, 5'd9);
        check("frz_yaz_en", bus.yazmaca_yaz_o, 1'b1);
        tick();
        check("frz_bitti_gecerli", bus.sonuc_gecerli_o, 1'b0);
        check("frz_bitti_stall", bus.yurut_stall_o, 1'b0);

        // Reset in MESGUL, done pulse right after
        bus.istek_gecerli_i = 1'b1; bus.birim_sec_i = 2'b00;
        bus.hedef_yazmaci_i = 5'd3; bus.yazmaca_yaz_i = 1'b1;
        tick();
        bus.istek_gecerli_i = 1'b0;
        check("rm_baslat", bus.baslat_o, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.birim_hazir_i = 3'b001; bus.amb_sonuc_i = 32'h0000_0055;
        check("rm_stall", bus.yurut_stall_o, 1'b0);
        check("rm_baslat0", bus.baslat_o, 3'b000);
        check("rm_hedef", bus.hedef_yazmaci_o, 5'h0);
        tick();
        bus.birim_hazir_i = 3'b000;
        check("rm_gecerli", bus.sonuc_gecerli_o, 1'b0);
        check("rm_sonuc", bus.sonuc_o, 32'h0);
        check("rm_yaz", bus.yazmaca_yaz_o, 1'b0);
        tick();
        check("rm_gecerli2", bus.sonuc_gecerli_o, 1'b0);

        // Freeze in BOSTA holds off acceptance
        bus.durdur_i = 1'b1; bus.istek_gecerli_i = 1'b1; bus.birim_sec_i = 2'b00;
        bus.hedef_yazmaci_i = 5'd1; bus.yazmaca_yaz_i = 1'b0;
        tick();
        check("bf_baslat", bus.baslat_o, 3'b000);
        check("bf_stall", bus.yurut_stall_o, 1'b0);
        bus.durdur_i = 1'b0;
        tick();
        bus.istek_gecerli_i = 1'b0;
        check("bf_kabul", bus.baslat_o, 3'b001);
        bus.birim_hazir_i = 3'b001; bus.amb_sonuc_i = 32'h0000_0077;
        tick();
        bus.birim_hazir_i = 3'b000;
        check("bf_sonuc", bus.sonuc_o, 32'h0000_0077);
        check("bf_yaz", bus.yazmaca_yaz_o, 1'b0);
        check("bf_gecerli", bus.sonuc_gecerli_o, 1'b1);
        tick();
        check("bf_bitti", bus.yurut_stall_o, 1'b0);

`ifdef YURUT_ZAMAN_ASIMI_EN
        // Unit never answers: abort after ZAMAN_ASIMI MESGUL cycles
        idle_inputs();
        bus.istek_gecerli_i = 1'b1; bus.birim_sec_i = 2'b10;
        bus.hedef_yazmaci_i = 5'd4; bus.yazmaca_yaz_i = 1'b1;
        bus.kripto_sonuc_i = 32'hFFFF_0000;
        tick();
        bus.istek_gecerli_i = 1'b0;
        for (int i = 0; i < ZAMAN_ASIMI; i++) begin
            check("wd_bekle_gecerli", bus.sonuc_gecerli_o, 1'b0);
            check("wd_bekle_hata", bus.hata_o, 1'b0);
            tick();
        end
        check("wd_gecerli", bus.sonuc_gecerli_o, 1'b1);
        check("wd_hata", bus.hata_o, 1'b1);
        check("wd_sonuc", bus.sonuc_o, 32'h0);
        check("wd_yaz", bus.yazmaca_yaz_o, 1'b0);
        tick();
        check("wd_bitti_hata", bus.hata_o, 1'b0);
        check("wd_bitti_stall", bus.yurut_stall_o, 1'b0);
`endif

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0] s;
            s = 2'($urandom_range(3));
            run_op(s, 5'($urandom), 1'($urandom), $urandom_range(1, 6), $urandom,
                   $urandom_range(50), $urandom_range(50),
                   (s == 2'b11) ? 3'b000 : 3'(3'b001 << s), (s == 2'b11));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
